fpu_shared_arbiter: RTL and testbench

//  Shares one FPU port (request/gnt + rvalid/rready protocol) between NB_CORES core-side requesters.

---
 rtl/fpu_shared_arbiter.sv | 172 +++++++++++++++++
 tb/tb_fpu_shared_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_shared_arbiter.sv
// fpu_shared_arbiter
//   Shares a single FPU slave port between NB_CORES core-side requesters.
//   Round-robin arbitration with a lock: once a winner has been presented to
//   the FPU without a grant, it is held until the grant arrives. Granted
//   requester IDs are pushed into a tag FIFO so that in-order FPU responses
//   can be routed back to the core that issued them.
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   core_*_i/_o       per-core request/grant, payload, response handshake
//   core_rdata_o      shared result bus, qualified by core_rvalid_o
//   fpu_*_o/_i        single FPU request/grant and response handshake
//   busy_o            outstanding responses or a held lock
//   unexp_rsp_o       FPU response seen with no outstanding tag (drained)
module fpu_shared_arbiter #(
  parameter int unsigned NB_CORES        = 4,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned NB_ARGS         = 3,
  parameter int unsigned OPCODE_WIDTH    = 6,
  parameter int unsigned DSFLAGS_WIDTH   = 15,
  parameter int unsigned USFLAGS_WIDTH   = 5,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic [NB_CORES-1:0]                      core_req_i,
  output logic [NB_CORES-1:0]                      core_gnt_o,
  input  logic [NB_CORES*NB_ARGS*DATA_WIDTH-1:0]   core_operands_i,
  input  logic [NB_CORES*OPCODE_WIDTH-1:0]         core_op_i,
  input  logic [NB_CORES*DSFLAGS_WIDTH-1:0]        core_flags_i,
  input  logic [NB_CORES-1:0]                      core_rready_i,
  output logic [NB_CORES-1:0]                      core_rvalid_o,
  output logic [DATA_WIDTH-1:0]                    core_rdata_o,
  output logic [USFLAGS_WIDTH-1:0]                 core_rflags_o,
  output logic                                     fpu_req_o,
  input  logic                                     fpu_gnt_i,
  output logic [NB_ARGS*DATA_WIDTH-1:0]            fpu_operands_o,
  output logic [OPCODE_WIDTH-1:0]                  fpu_op_o,
  output logic [DSFLAGS_WIDTH-1:0]                 fpu_flags_o,
  output logic                                     fpu_rready_o,
  input  logic                                     fpu_rvalid_i,
  input  logic [DATA_WIDTH-1:0]                    fpu_rdata_i,
  input  logic [USFLAGS_WIDTH-1:0]                 fpu_rflags_i,
  output logic                                     busy_o,
  output logic                                     unexp_rsp_o
);

  localparam int unsigned IDW = (NB_CORES > 1) ? $clog2(NB_CORES) : 1;
  localparam int unsigned PW  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CW  = $clog2(MAX_OUTSTANDING) + 1;
  localparam int unsigned OPW = NB_ARGS * DATA_WIDTH;

  typedef enum logic {FREE, LOCKED} state_e;

  state_e           state_q, state_d;
  logic [IDW-1:0]   lock_id_q, lock_id_d;
  logic [IDW-1:0]   rr_q, rr_d;
  logic [IDW-1:0]   fifo_q [MAX_OUTSTANDING];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    cnt_q;

  logic [IDW-1:0]   rr_win, win, win_next, head;
  logic             rr_hit, req_any;
  logic             fifo_full, fifo_empty, push, pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + PW'(1);
  endfunction

  assign fifo_full  = (cnt_q == CW'(MAX_OUTSTANDING));
  assign fifo_empty = (cnt_q == '0);
  assign head       = fifo_q[rd_ptr_q];

  // First requester at or after the RR pointer, wrapping around.
  always_comb begin
    rr_win = '0;
    rr_hit = 1'b0;
    for (int unsigned i = 0; i < NB_CORES; i++) begin
      if (!rr_hit && core_req_i[IDW'((32'(rr_q) + i) % NB_CORES)]) begin
        rr_hit = 1'b1;
        rr_win = IDW'((32'(rr_q) + i) % NB_CORES);
      end
    end
  end

  // While locked, only the locked core is considered; everyone else waits.
  always_comb begin
    if (state_q == LOCKED) begin
      win     = lock_id_q;
      req_any = core_req_i[lock_id_q];
    end else begin
      win     = rr_win;
      req_any = rr_hit;
    end
  end

  assign win_next  = (win == IDW'(NB_CORES - 1)) ? '0 : win + IDW'(1);
  // No same-cycle pop bypass: a full FIFO blocks new requests outright.
  assign fpu_req_o = req_any & ~fifo_full;
  assign push      = fpu_req_o & fpu_gnt_i;

  always_comb begin
    core_gnt_o = '0;
    if (push) core_gnt_o[win] = 1'b1;
  end

  assign fpu_operands_o = fpu_req_o ? core_operands_i[win*OPW +: OPW]                    : '0;
  assign fpu_op_o       = fpu_req_o ? core_op_i[win*OPCODE_WIDTH +: OPCODE_WIDTH]        : '0;
  assign fpu_flags_o    = fpu_req_o ? core_flags_i[win*DSFLAGS_WIDTH +: DSFLAGS_WIDTH]   : '0;

  always_comb begin
    state_d   = state_q;
    lock_id_d = lock_id_q;
    rr_d      = rr_q;
    if (state_q == FREE) begin
      if (push) begin
        rr_d = win_next;
      end else if (fpu_req_o) begin
        state_d   = LOCKED;
        lock_id_d = win;
      end
    end else begin
      if (!req_any) begin
        state_d = FREE;
      end else if (push) begin
        rr_d    = win_next;
        state_d = FREE;
      end
    end
  end

  // Responses follow the head tag; with no tag outstanding they are drained.
  always_comb begin
    core_rvalid_o = '0;
    fpu_rready_o  = 1'b1;
    unexp_rsp_o   = 1'b0;
    if (fifo_empty) begin
      unexp_rsp_o = fpu_rvalid_i;
    end else begin
      core_rvalid_o[head] = fpu_rvalid_i;
      fpu_rready_o        = core_rready_i[head];
    end
  end

  assign pop           = fpu_rvalid_i & fpu_rready_o & ~fifo_empty;
  assign core_rdata_o  = fpu_rdata_i;
  assign core_rflags_o = fpu_rflags_i;
  assign busy_o        = ~fifo_empty | (state_q == LOCKED);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FREE;
      lock_id_q <= '0;
      rr_q      <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      lock_id_q <= lock_id_d;
      rr_q      <= rr_d;
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (push && !pop)      cnt_q <= cnt_q + CW'(1);
      else if (!push && pop) cnt_q <= cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= win;
  end

endmodule

// File: tb/tb_fpu_shared_arbiter.sv
// tb_fpu_shared_arbiter
//   Directed scenarios followed by random traffic. A queue-based reference
//   model of the arbiter predicts every output each cycle.
module tb_fpu_shared_arbiter;

  localparam int NC = 4;
  localparam int DW = 32;
  localparam int NA = 3;
  localparam int OW = 6;
  localparam int DF = 15;
  localparam int UF = 5;
  localparam int MO = 4;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NC-1:0]        core_req_i;
  logic [NC-1:0]        core_gnt_o;
  logic [NC*NA*DW-1:0]  core_operands_i;
  logic [NC*OW-1:0]     core_op_i;
  logic [NC*DF-1:0]     core_flags_i;
  logic [NC-1:0]        core_rready_i;
  logic [NC-1:0]        core_rvalid_o;
  logic [DW-1:0]        core_rdata_o;
  logic [UF-1:0]        core_rflags_o;
  logic                 fpu_req_o;
  logic                 fpu_gnt_i;
  logic [NA*DW-1:0]     fpu_operands_o;
  logic [OW-1:0]        fpu_op_o;
  logic [DF-1:0]        fpu_flags_o;
  logic                 fpu_rready_o;
  logic                 fpu_rvalid_i;
  logic [DW-1:0]        fpu_rdata_i;
  logic [UF-1:0]        fpu_rflags_i;
  logic                 busy_o;
  logic                 unexp_rsp_o;

  fpu_shared_arbiter #(
    .NB_CORES(NC), .DATA_WIDTH(DW), .NB_ARGS(NA), .OPCODE_WIDTH(OW),
    .DSFLAGS_WIDTH(DF), .USFLAGS_WIDTH(UF), .MAX_OUTSTANDING(MO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .core_req_i(core_req_i), .core_gnt_o(core_gnt_o),
    .core_operands_i(core_operands_i), .core_op_i(core_op_i),
    .core_flags_i(core_flags_i), .core_rready_i(core_rready_i),
    .core_rvalid_o(core_rvalid_o), .core_rdata_o(core_rdata_o),
    .core_rflags_o(core_rflags_o), .fpu_req_o(fpu_req_o),
    .fpu_gnt_i(fpu_gnt_i), .fpu_operands_o(fpu_operands_o),
    .fpu_op_o(fpu_op_o), .fpu_flags_o(fpu_flags_o),
    .fpu_rready_o(fpu_rready_o), .fpu_rvalid_i(fpu_rvalid_i),
    .fpu_rdata_i(fpu_rdata_i), .fpu_rflags_i(fpu_rflags_i),
    .busy_o(busy_o), .unexp_rsp_o(unexp_rsp_o)
  );

  always #5 clk = ~clk;

  int nchk  = 0;
  int npass = 0;

  // Reference model: round-robin pointer, lock, queue of granted core IDs.
  int m_rr = 0;
  bit m_locked = 1'b0;
  int m_lid = 0;
  int m_q[$];

  bit              e_req;
  int              e_win;
  logic [NC-1:0]   e_gnt, e_rvalid;
  logic            e_rready, e_unexp, e_busy;
  logic [OW-1:0]   e_op;
  logic [NA*DW-1:0] e_opnd;
  logic [DF-1:0]   e_flags;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_eval();
    bit any = 1'b0;
    e_win = 0;
    if (m_locked) begin
      e_win = m_lid;
      any   = core_req_i[m_lid];
    end else begin
      for (int k = 0; k < NC; k++) begin
        int c = (m_rr + k) % NC;
        if (!any && core_req_i[c]) begin
          any   = 1'b1;
          e_win = c;
        end
      end
    end
    e_req = any && (m_q.size() < MO);
    e_gnt = '0;
    if (e_req && fpu_gnt_i) e_gnt[e_win] = 1'b1;
    e_op    = e_req ? core_op_i[e_win*OW +: OW] : '0;
    e_opnd  = e_req ? core_operands_i[e_win*NA*DW +: NA*DW] : '0;
    e_flags = e_req ? core_flags_i[e_win*DF +: DF] : '0;
    e_rvalid = '0;
    if (m_q.size() == 0) begin
      e_rready = 1'b1;
      e_unexp  = fpu_rvalid_i;
    end else begin
      e_rvalid[m_q[0]] = fpu_rvalid_i;
      e_rready = core_rready_i[m_q[0]];
      e_unexp  = 1'b0;
    end
    e_busy = (m_q.size() != 0) || m_locked;
  endtask

  task automatic model_check();
    chk("fpu_req",   128'(fpu_req_o),      128'(e_req));
    chk("core_gnt",  128'(core_gnt_o),     128'(e_gnt));
    chk("fpu_op",    128'(fpu_op_o),       128'(e_op));
    chk("fpu_opnd",  128'(fpu_operands_o), 128'(e_opnd));
    chk("fpu_flags", 128'(fpu_flags_o),    128'(e_flags));
    chk("rvalid",    128'(core_rvalid_o),  128'(e_rvalid));
    chk("rready",    128'(fpu_rready_o),   128'(e_rready));
    chk("unexp",     128'(unexp_rsp_o),    128'(e_unexp));
    chk("busy",      128'(busy_o),         128'(e_busy));
    chk("rdata",     128'(core_rdata_o),   128'(fpu_rdata_i));
  endtask

  task automatic model_update();
    model_eval();
    if (m_q.size() > 0 && fpu_rvalid_i && core_rready_i[m_q[0]]) void'(m_q.pop_front());
    if (e_req && fpu_gnt_i) begin
      m_q.push_back(e_win);
      m_rr     = (e_win + 1) % NC;
      m_locked = 1'b0;
    end else if (m_locked && !core_req_i[m_lid]) begin
      m_locked = 1'b0;
    end else if (e_req) begin
      m_locked = 1'b1;
      m_lid    = e_win;
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_rr     = 0;
    m_locked = 1'b0;
  endtask

  task automatic settle();
    @(negedge clk);
    model_eval();
    model_check();
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic clr_in();
    core_req_i = '0; core_rready_i = '0; fpu_gnt_i = 1'b0; fpu_rvalid_i = 1'b0;
    fpu_rdata_i = '0; fpu_rflags_i = '0;
    core_operands_i = '0; core_op_i = '0; core_flags_i = '0;
  endtask

  task automatic rand_payload();
    for (int w = 0; w < NC*NA; w++) core_operands_i[w*DW +: DW] = $urandom;
    for (int c = 0; c < NC; c++) begin
      core_op_i[c*OW +: OW]    = OW'($urandom);
      core_flags_i[c*DF +: DF] = DF'($urandom);
    end
    fpu_rdata_i  = $urandom;
    fpu_rflags_i = UF'($urandom);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clr_in();
    model_reset();
    #2;
    chk("rst_busy",   128'(busy_o),        128'(0));
    chk("rst_req",    128'(fpu_req_o),     128'(0));
    chk("rst_gnt",    128'(core_gnt_o),    128'(0));
    chk("rst_rvalid", 128'(core_rvalid_o), 128'(0));
    chk("rst_op",     128'(fpu_op_o),      128'(0));
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  logic [OW-1:0] op1;
  logic [3:0] gseq [4];
  logic [3:0] vseq [4];
  logic [3:0] g2seq [5];

  initial begin
    rst_n = 1'b1;
    clr_in();
    do_reset();

    // Cores 0 and 2 alternate; responses return to 0 then 2.
    gseq = '{4'b0001, 4'b0100, 4'b0001, 4'b0100};
    vseq = '{4'b0000, 4'b0001, 4'b0100, 4'b0001};
    core_req_i = 4'b0101; fpu_gnt_i = 1'b1; core_rready_i = '1;
    for (int i = 0; i < 4; i++) begin
      fpu_rvalid_i = (i > 0);
      rand_payload();
      settle();
      chk("t1_gnt",    128'(core_gnt_o),    128'(gseq[i]));
      chk("t1_rvalid", 128'(core_rvalid_o), 128'(vseq[i]));
      tick();
    end

    // All request, no responses: four grants, then blocked by full FIFO.
    do_reset();
    g2seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000};
    core_req_i = 4'b1111; fpu_gnt_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      settle();
      chk("t2_gnt", 128'(core_gnt_o), 128'(g2seq[i]));
      chk("t2_req", 128'(fpu_req_o),  128'(i < 4));
      tick();
    end

    // Lock holds core1 while core0 raises its request.
    do_reset();
    rand_payload();
    op1 = core_op_i[1*OW +: OW];
    core_req_i = 4'b0010; fpu_gnt_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) core_req_i = 4'b0011;
      settle();
      chk("t3_op",  128'(fpu_op_o), 128'(op1));
      chk("t3_req", 128'(fpu_req_o), 128'(1));
      tick();
    end
    fpu_gnt_i = 1'b1;
    settle();
    chk("t3_gnt", 128'(core_gnt_o), 128'(4'b0010));
    tick();

    // Response to core3 stalled by rready, then popped.
    do_reset();
    core_req_i = 4'b1000; fpu_gnt_i = 1'b1;
    settle(); tick();
    core_req_i = '0; fpu_gnt_i = 1'b0; fpu_rvalid_i = 1'b1; core_rready_i = 4'b0111;
    for (int i = 0; i < 2; i++) begin
      settle();
      chk("t4_rvalid", 128'(core_rvalid_o), 128'(4'b1000));
      chk("t4_rready", 128'(fpu_rready_o),  128'(0));
      tick();
    end
    core_rready_i = 4'b1111;
    settle();
    chk("t4_rready_go", 128'(fpu_rready_o), 128'(1));
    tick();
    fpu_rvalid_i = 1'b0;
    settle();
    chk("t4_busy", 128'(busy_o), 128'(0));
    tick();

    // Unexpected response while nothing is outstanding.
    do_reset();
    fpu_rvalid_i = 1'b1; fpu_rdata_i = 32'h1234;
    settle();
    chk("t5_unexp",  128'(unexp_rsp_o),   128'(1));
    chk("t5_rvalid", 128'(core_rvalid_o), 128'(0));
    chk("t5_rdata",  128'(core_rdata_o),  128'(32'h1234));
    tick();
    fpu_rvalid_i = 1'b0;
    settle();
    chk("t5_unexp_end", 128'(unexp_rsp_o), 128'(0));
    tick();

    // Async reset with two outstanding; pointer returns to 0.
    do_reset();
    core_req_i = 4'b0011; fpu_gnt_i = 1'b1;
    settle(); tick();
    settle(); tick();
    clr_in();
    settle();
    chk("t6_busy_pre", 128'(busy_o), 128'(1));
    rst_n = 1'b0;
    #1;
    chk("t6_busy", 128'(busy_o), 128'(0));
    model_reset();
    #1;
    rst_n = 1'b1;
    tick();
    core_req_i = 4'b0110; fpu_gnt_i = 1'b1;
    settle();
    chk("t6_gnt_rr", 128'(core_gnt_o), 128'(4'b0010));
    tick();
    core_req_i = 4'b0100; fpu_rvalid_i = 1'b0;
    settle();
    chk("t6_gnt2", 128'(core_gnt_o), 128'(4'b0100));
    tick();

    // Random traffic against the model.
    for (int n = 0; n < 600; n++) begin
      core_req_i    = NC'($urandom);
      fpu_gnt_i     = ($urandom_range(0, 2) == 0);
      fpu_rvalid_i  = ($urandom_range(0, 1) == 0);
      core_rready_i = NC'($urandom) | NC'($urandom);
      rand_payload();
      settle();
      tick();
    end

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
